mag_comp_8: RTL and testbench
=============================

# mag_comp_8

Registered 8-bit magnitude comparator. Each accepted cycle it compares two operands and reports exactly one of equal, greater-than or less-than on one-hot registered flags. It serves as a leaf compare block for datapath control logic such as threshold checks and min/max selection. It is built from cascaded 4-bit slices so the width can scale in nibble steps.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on data_in1/data_in2 are valid this cycle.
- data_in1  input  WIDTH  operand A.
- data_in2  input  WIDTH  operand B.
- out_valid  output  1  eq/gt/lt updated from an accepted sample on the last edge.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

## Operation
- Compare is unsigned by default. Signed mode is available under the macro in Configuration.
- The operand is split into WIDTH/4 nibbles, each fed to a comp_4_slice.
- Slices cascade from MSB nibble to LSB nibble:
  - The first slice whose nibbles differ decides gt/lt.
  - If every slice reports equal, the result is eq.
- Cascade rule per slice:
  - Cascade-in gt or lt is passed through unchanged.
  - Otherwise the slice's own nibble compare decides.
  - The MSB slice has cascade-in fixed to eq=1, gt=0, lt=0.
- Accept: when in_valid=1 at a rising edge, the cascade result loads into eq/gt/lt, and out_valid is set to 1.
- Hold: when in_valid=0, eq/gt/lt keep their previous values and out_valid is cleared to 0.
- Invariant: after the first accepted sample, exactly one of eq/gt/lt is 1.
- Before any accepted sample, all three flags are 0.
- No X propagation requirement beyond the inputs; X inputs may yield X flags.

## Timing
- Reset (asynchronous, takes effect immediately while rst=1): eq=0, gt=0, lt=0, out_valid=0.
- Latency is 1 cycle. Operands present with in_valid=1 at edge k are reflected on eq/gt/lt and out_valid=1 immediately after edge k.
- Back-to-back accepts are supported (throughput 1 compare per cycle). There is no backpressure and no ready signal.
- Reset deasserted mid-stream: the first edge after rst falls behaves as a normal accept or hold.
- An operand change without in_valid has no effect on the outputs.
- Combinational path runs from the operand inputs through WIDTH/4 slices to the flag registers. There are no combinational input-to-output paths.

## Configuration
- MAG_COMP_8_SIGNED_EN:
  - Defined: operands are two's complement. The MSB slice treats bit WIDTH-1 as sign, so negative < positive; e.g. 8'hFF (-1) vs 8'h01 gives lt=1.
  - Undefined: unsigned compare; 8'hFF vs 8'h01 gives gt=1.
- All other behaviour is identical in both builds.

## Structure
- Package mag_comp_8_pkg:
  - Localparam SLICE_W=4.
  - Default WIDTH=8.
  - Typedef cmp_res_t, a packed struct {eq, gt, lt} used for slice cascade and output registers.
  - Reset constant CMP_RES_RST = '{0,0,0}.
- Sub-module comp_4_slice:
  - Ports: 4-bit a and b, cmp_res_t cascade-in, cmp_res_t result.
  - Parameter IS_MSB_SIGNED selects sign handling, driven only when the macro is defined and the slice is the top one.
  - Purely combinational.
- Top level: generate loop of comp_4_slice, then the flag and out_valid registers.

## Test plan
- Reset: assert rst with in_valid=1 and operands toggling -> eq=gt=lt=0, out_valid=0 throughout.
- A=69, B=96, in_valid=1 -> after edge: lt=1, eq=0, gt=0, out_valid=1.
- A=99, B=96 -> gt=1. Then A=69, B=69 -> eq=1. Applied on consecutive edges, flags change every cycle with out_valid held at 1.
- Nibble cascade: A=8'h3A vs B=8'h3B -> lt=1. A=8'h40 vs B=8'h3F -> gt=1. Boundaries 8'h00 vs 8'h00 -> eq=1; 8'hFF vs 8'h00 -> gt=1 (unsigned build).
- Hold: accept A=99, B=96, then drop in_valid and change A to 0 -> gt stays 1, out_valid=0.
- Signed build (MAG_COMP_8_SIGNED_EN): 8'hFF vs 8'h01 -> lt=1. 8'h80 vs 8'h7F -> lt=1. 8'hFE vs 8'hFD -> gt=1.

Source files
------------

// File: rtl/mag_comp_8_pkg.sv
// Shared types and constants for the cascaded nibble magnitude comparator.
package mag_comp_8_pkg;

  localparam int unsigned SLICE_W   = 4;
  localparam int unsigned WIDTH_DEF = 8;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_RST = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

endpackage

// File: rtl/mag_comp_8_comp_4_slice.sv
// One 4-bit compare stage; a decided gt/lt from the more significant side wins.
module comp_4_slice
  import mag_comp_8_pkg::*;
#(
  parameter bit IS_MSB_SIGNED = 1'b0
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  cmp_res_t           cas_in,
  output cmp_res_t           result
);

  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [SLICE_W-1:0] SIGN_FLIP = {IS_MSB_SIGNED, (SLICE_W-1)'(0)};

  logic [SLICE_W-1:0] a_adj;
  logic [SLICE_W-1:0] b_adj;

  always_comb begin
    a_adj  = a ^ SIGN_FLIP;
    b_adj  = b ^ SIGN_FLIP;
    result = CMP_RES_RST;
    if (cas_in.gt || cas_in.lt) begin
      result = cas_in;
    end else if (a_adj > b_adj) begin
      result.gt = 1'b1;
    end else if (a_adj < b_adj) begin
      result.lt = 1'b1;
    end else begin
      result.eq = 1'b1;
    end
  end

endmodule

// File: rtl/mag_comp_8.sv
// Registered magnitude comparator built from cascaded 4-bit slices.
// Define MAG_COMP_8_SIGNED_EN for two's complement operands (default unsigned).
module mag_comp_8
  import mag_comp_8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

`ifdef MAG_COMP_8_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // casc[NSLICE] seeds the MSB slice; casc[0] is the full-width result.
  cmp_res_t casc [NSLICE+1];

  assign casc[NSLICE] = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    comp_4_slice #(
      .IS_MSB_SIGNED (SIGNED_EN && (i == NSLICE - 1))
    ) u_slice (
      .a      (data_in1[i*SLICE_W +: SLICE_W]),
      .b      (data_in2[i*SLICE_W +: SLICE_W]),
      .cas_in (casc[i+1]),
      .result (casc[i])
    );
  end

  cmp_res_t res_q, res_d;
  logic     vld_q, vld_d;

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    if (in_valid) begin
      res_d = casc[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= CMP_RES_RST;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign eq        = res_q.eq;
  assign gt        = res_q.gt;
  assign lt        = res_q.lt;

endmodule

// File: tb/tb_mag_comp_8.sv
// Directed bench for mag_comp_8; expected flags are hand-computed per vector.
module tb_mag_comp_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic       out_valid;
  logic       eq;
  logic       gt;
  logic       lt;

  int tests = 0;
  int fails = 0;

  mag_comp_8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .out_valid (out_valid),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  // exp packs {out_valid, eq, gt, lt}
  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {out_valid, eq, gt, lt};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {v,eq,gt,lt}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v,
                      input string tag, input logic [3:0] exp);
    @(negedge clk);
    data_in1 = a;
    data_in2 = b;
    in_valid = v;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in1 = 8'd0;
    data_in2 = 8'd0;
    #1;
    check("reset_initial", 4'b0000);

    step(8'h12, 8'h34, 1'b1, "reset_hold_lt", 4'b0000);
    step(8'h90, 8'h10, 1'b1, "reset_hold_gt", 4'b0000);
    step(8'h55, 8'h55, 1'b1, "reset_hold_eq", 4'b0000);

    @(negedge clk);
    rst = 1'b0;

    step(8'd69, 8'd96, 1'b1, "a69_b96_lt",  4'b1001);
    step(8'd99, 8'd96, 1'b1, "a99_b96_gt",  4'b1010);
    step(8'd69, 8'd69, 1'b1, "a69_b69_eq",  4'b1100);

    step(8'h3A, 8'h3B, 1'b1, "lsb_nib_lt",  4'b1001);
    step(8'h40, 8'h3F, 1'b1, "msb_nib_gt",  4'b1010);
    step(8'h00, 8'h00, 1'b1, "zero_eq",     4'b1100);

    step(8'd99, 8'd96, 1'b1, "hold_setup",  4'b1010);
    step(8'd0,  8'd96, 1'b0, "hold_a0",     4'b0010);
    step(8'd0,  8'd0,  1'b0, "hold_again",  4'b0010);

`ifdef MAG_COMP_8_SIGNED_EN
    step(8'hFF, 8'h00, 1'b1, "ff_vs_00",    4'b1001);
    step(8'hFF, 8'h01, 1'b1, "ff_vs_01",    4'b1001);
    step(8'h80, 8'h7F, 1'b1, "80_vs_7f",    4'b1001);
    step(8'hFE, 8'hFD, 1'b1, "fe_vs_fd",    4'b1010);
    step(8'h7F, 8'h80, 1'b1, "7f_vs_80",    4'b1010);
`else
    step(8'hFF, 8'h00, 1'b1, "ff_vs_00",    4'b1010);
    step(8'hFF, 8'h01, 1'b1, "ff_vs_01",    4'b1010);
    step(8'h80, 8'h7F, 1'b1, "80_vs_7f",    4'b1010);
    step(8'hFE, 8'hFD, 1'b1, "fe_vs_fd",    4'b1010);
    step(8'h7F, 8'h80, 1'b1, "7f_vs_80",    4'b1001);
`endif

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    step(8'h05, 8'h05, 1'b1, "post_reset_eq", 4'b1100);
    step(8'h05, 8'h50, 1'b1, "post_reset_lt", 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
